// File: rtl/armleocpu_defines.sv
// Shared Sv32 walker definitions: PTE bit positions, walker states, bus response codes.
package armleocpu_defines;

  localparam int unsigned PHYS_W = 22;
  localparam int unsigned VPN_W  = 20;
  localparam int unsigned IDX_W  = 10;
  localparam int unsigned ADDR_W = 34;
  localparam int unsigned TAG_W  = 8;

  localparam int unsigned PTE_V = 0;
  localparam int unsigned PTE_R = 1;
  localparam int unsigned PTE_W = 2;
  localparam int unsigned PTE_X = 3;
  localparam int unsigned PTE_U = 4;
  localparam int unsigned PTE_G = 5;
  localparam int unsigned PTE_A = 6;
  localparam int unsigned PTE_D = 7;

  localparam logic [1:0] AVL_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } ptw_state_t;

  typedef enum logic [1:0] {
    PTE_LEAF    = 2'd0,
    PTE_POINTER = 2'd1,
    PTE_FAULT   = 2'd2
  } pte_kind_t;

endpackage

// File: rtl/armleocpu_ptw.sv
// Sv32 page-table walker: reads up to two PTEs and returns a TLB-ready tag/PPN or a fault.
module armleocpu_ptw
  import armleocpu_defines::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                resolve_request,
  input  logic [VPN_W-1:0]    resolve_virtual_address,
  input  logic [PHYS_W-1:0]   satp_ppn,
  output logic                resolve_ack,
  output logic                resolve_pagefault,
  output logic                resolve_accessfault,
  output logic [TAG_W-1:0]    resolve_accesstag,
  output logic [PHYS_W-1:0]   resolve_physical_address,
  output logic [ADDR_W-1:0]   avl_address,
  output logic                avl_read,
  input  logic                avl_waitrequest,
  input  logic                avl_readdatavalid,
  input  logic [31:0]         avl_readdata,
  input  logic [1:0]          avl_response
);

  ptw_state_t          state_q, state_d;
  logic                level_q, level_d;
  logic [IDX_W-1:0]    vpn0_q, vpn0_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                read_q, read_d;
  logic                ack_q, ack_d;
  logic                pf_q, pf_d;
  logic                af_q, af_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [PHYS_W-1:0]   phys_q, phys_d;

  // RSW bits carry no meaning for the walker.
  logic unused_rsw;
  assign unused_rsw = &{1'b0, avl_readdata[9:8]};

  // Classify a PTE fetched at the given level.
  function automatic pte_kind_t classify(input logic [31:0] pte, input logic level);
    if (!pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W]))
      return PTE_FAULT;
    if (pte[PTE_R] || pte[PTE_X])
      return (level && (pte[19:10] != IDX_W'(0))) ? PTE_FAULT : PTE_LEAF;
    return level ? PTE_POINTER : PTE_FAULT;
  endfunction

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    vpn0_d  = vpn0_q;
    addr_d  = addr_q;
    read_d  = read_q;
    ack_d   = ack_q;
    pf_d    = pf_q;
    af_d    = af_q;
    tag_d   = tag_q;
    phys_d  = phys_q;
    unique case (state_q)
      IDLE: begin
        if (resolve_request) begin
          vpn0_d  = resolve_virtual_address[IDX_W-1:0];
          level_d = 1'b1;
          addr_d  = {satp_ppn, resolve_virtual_address[VPN_W-1:IDX_W], 2'b00};
          read_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!avl_waitrequest) begin
          read_d  = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (avl_readdatavalid) begin
          if (avl_response != AVL_OKAY) begin
            af_d    = 1'b1;
            ack_d   = 1'b1;
            tag_d   = '0;
            phys_d  = '0;
            state_d = ACK;
          end else begin
            unique case (classify(avl_readdata, level_q))
              PTE_LEAF: begin
                ack_d   = 1'b1;
                tag_d   = avl_readdata[TAG_W-1:0];
                phys_d  = level_q ? {avl_readdata[31:20], vpn0_q} : avl_readdata[31:10];
                state_d = ACK;
              end
              PTE_POINTER: begin
                level_d = 1'b0;
                addr_d  = {avl_readdata[31:10], vpn0_q, 2'b00};
                read_d  = 1'b1;
                state_d = ISSUE;
              end
              default: begin
                pf_d    = 1'b1;
                ack_d   = 1'b1;
                tag_d   = '0;
                phys_d  = '0;
                state_d = ACK;
              end
            endcase
          end
        end
      end
      ACK: begin
        ack_d   = 1'b0;
        pf_d    = 1'b0;
        af_d    = 1'b0;
        tag_d   = '0;
        phys_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      level_q <= 1'b0;
      vpn0_q  <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      ack_q   <= 1'b0;
      pf_q    <= 1'b0;
      af_q    <= 1'b0;
      tag_q   <= '0;
      phys_q  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      vpn0_q  <= vpn0_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      ack_q   <= ack_d;
      pf_q    <= pf_d;
      af_q    <= af_d;
      tag_q   <= tag_d;
      phys_q  <= phys_d;
    end
  end

  assign resolve_ack              = ack_q;
  assign resolve_pagefault        = pf_q;
  assign resolve_accessfault      = af_q;
  assign resolve_accesstag        = tag_q;
  assign resolve_physical_address = phys_q;
  assign avl_address              = addr_q;
  assign avl_read                 = read_q;

endmodule

// File: tb/tb_armleocpu_ptw.sv
// Bench for the Sv32 walker: memory-backed bus responder plus a table-walk reference model.
module tb_armleocpu_ptw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        resolve_request = 1'b0;
  logic [19:0] resolve_virtual_address = '0;
  logic [21:0] satp_ppn = '0;
  logic        resolve_ack, resolve_pagefault, resolve_accessfault;
  logic [7:0]  resolve_accesstag;
  logic [21:0] resolve_physical_address;
  logic [33:0] avl_address;
  logic        avl_read;
  logic        avl_waitrequest = 1'b1;
  logic        avl_readdatavalid = 1'b0;
  logic [31:0] avl_readdata = '0;
  logic [1:0]  avl_response = '0;

  always #5 clk = ~clk;

  armleocpu_ptw dut (
    .clk(clk), .rst_n(rst_n),
    .resolve_request(resolve_request),
    .resolve_virtual_address(resolve_virtual_address),
    .satp_ppn(satp_ppn),
    .resolve_ack(resolve_ack),
    .resolve_pagefault(resolve_pagefault),
    .resolve_accessfault(resolve_accessfault),
    .resolve_accesstag(resolve_accesstag),
    .resolve_physical_address(resolve_physical_address),
    .avl_address(avl_address),
    .avl_read(avl_read),
    .avl_waitrequest(avl_waitrequest),
    .avl_readdatavalid(avl_readdatavalid),
    .avl_readdata(avl_readdata),
    .avl_response(avl_response)
  );

  logic [31:0] mem [logic [33:0]];
  bit          err_map [logic [33:0]];

  int compared = 0;
  int mismatched = 0;
  int cfg_stall = 0;
  int cfg_delay = 0;
  bit rand_bus = 1'b0;
  int reads = 0;

  bit          exp_pending = 1'b0;
  bit          exp_pf, exp_af;
  logic [7:0]  exp_tag;
  logic [21:0] exp_phys;
  int          exp_n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [33:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Walk the tables as the Sv32 rules describe, level 1 then level 0.
  task automatic model_walk(input logic [19:0] vpn, input logic [21:0] satp,
                            output bit pf, output bit af, output logic [7:0] tag,
                            output logic [21:0] phys, output int n);
    logic [21:0] tbl;
    logic [9:0]  idx;
    logic [33:0] a;
    logic [31:0] p;
    tbl = satp; pf = 0; af = 0; tag = 0; phys = 0; n = 0;
    for (int lvl = 1; lvl >= 0; lvl--) begin
      idx = (lvl == 1) ? vpn[19:10] : vpn[9:0];
      a = {tbl, idx, 2'b00};
      n++;
      if (err_map.exists(a)) begin af = 1; return; end
      p = rd(a);
      if (!p[0] || (p[2] && !p[1])) begin pf = 1; return; end
      if (p[1] || p[3]) begin
        if (lvl == 1 && p[19:10] != 10'd0) begin pf = 1; return; end
        tag = p[7:0];
        phys = (lvl == 1) ? {p[31:20], vpn[9:0]} : p[31:10];
        return;
      end
      if (lvl == 0) begin pf = 1; return; end
      tbl = p[31:10];
    end
  endtask

  // Bus responder: optional stall, then data after a delay, from mem/err_map.
  initial begin
    int stall_left;
    int resp_delay;
    logic [33:0] held_addr;
    logic [33:0] acc_addr;
    stall_left = -1; resp_delay = -1; held_addr = '0; acc_addr = '0;
    forever begin
      @(negedge clk);
      avl_readdatavalid = 1'b0;
      avl_readdata = '0;
      avl_response = 2'b00;
      if (!rst_n) begin
        stall_left = -1; resp_delay = -1; avl_waitrequest = 1'b1;
      end else begin
        if (resp_delay == 0) begin
          avl_readdatavalid = 1'b1;
          avl_readdata = rd(acc_addr);
          avl_response = err_map.exists(acc_addr) ? 2'd2 : 2'd0;
          resp_delay = -1;
        end else if (resp_delay > 0) begin
          resp_delay--;
        end
        if (avl_read) begin
          if (stall_left < 0) begin
            stall_left = rand_bus ? int'($urandom_range(0, 2)) : cfg_stall;
            held_addr = avl_address;
          end else begin
            check("addr_stable", 64'(avl_address), 64'(held_addr));
          end
          if (stall_left > 0) begin
            avl_waitrequest = 1'b1;
            stall_left--;
          end else begin
            avl_waitrequest = 1'b0;
            stall_left = -1;
            acc_addr = held_addr;
            resp_delay = rand_bus ? int'($urandom_range(0, 3)) : cfg_delay;
            reads++;
          end
        end else begin
          avl_waitrequest = 1'b1;
        end
      end
    end
  end

  // Compare process: every ack must match the pending model result.
  always @(negedge clk) begin
    if (rst_n && resolve_ack) begin
      compared++;
      if (!exp_pending) begin
        mismatched++;
        $display("FAIL unexpected_ack: got ack=1 expected no walk in flight");
      end else begin
        check("ack_pagefault", 64'(resolve_pagefault), 64'(exp_pf));
        check("ack_accessfault", 64'(resolve_accessfault), 64'(exp_af));
        check("ack_tag", 64'(resolve_accesstag), 64'(exp_tag));
        check("ack_phys", 64'(resolve_physical_address), 64'(exp_phys));
        check("ack_reads", 64'(reads), 64'(exp_n));
      end
      exp_pending = 1'b0;
    end
  end

  task automatic walk(input logic [19:0] vpn, input logic [21:0] satp,
                      input bit hold_extra, output int lat);
    model_walk(vpn, satp, exp_pf, exp_af, exp_tag, exp_phys, exp_n);
    reads = 0;
    exp_pending = 1'b1;
    @(negedge clk);
    resolve_request = 1'b1;
    resolve_virtual_address = vpn;
    satp_ppn = satp;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        resolve_virtual_address = 20'($urandom);
        satp_ppn = 22'($urandom);
      end
      if (resolve_ack) break;
      if (lat > 300) begin
        compared++; mismatched++;
        $display("FAIL ack_timeout: got no ack after %0d cycles expected ack", lat);
        exp_pending = 1'b0;
        break;
      end
    end
    if (hold_extra) @(negedge clk);
    resolve_request = 1'b0;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, 64'(resolve_ack), 64'h0);
    check({tag, "_pf"}, 64'(resolve_pagefault), 64'h0);
    check({tag, "_af"}, 64'(resolve_accessfault), 64'h0);
    check({tag, "_tag"}, 64'(resolve_accesstag), 64'h0);
    check({tag, "_phys"}, 64'(resolve_physical_address), 64'h0);
    check({tag, "_read"}, 64'(avl_read), 64'h0);
  endtask

  task automatic load_two_level();
    mem.delete(); err_map.delete();
    mem[34'h1004] = 32'h0000_0C01;
    mem[34'h3008] = 32'h0000_40CF;
  endtask

  initial begin
    int lat;
    bit m_pf, m_af;
    logic [7:0] m_tag;
    logic [21:0] m_phys;
    int m_n;
    logic [19:0] vpn;
    logic [21:0] satp, ppn;
    logic [33:0] a1, a0;
    logic [31:0] pte;
    logic [2:0] rwx_opts [5];
    rwx_opts[0] = 3'b001; rwx_opts[1] = 3'b011; rwx_opts[2] = 3'b100;
    rwx_opts[3] = 3'b101; rwx_opts[4] = 3'b111;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_addr", 64'(avl_address), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-level walk with a zero-wait bus.
    load_two_level();
    model_walk(20'h00402, 22'h1, m_pf, m_af, m_tag, m_phys, m_n);
    check("model_2lvl_tag", 64'(m_tag), 64'hCF);
    check("model_2lvl_phys", 64'(m_phys), 64'h10);
    check("model_2lvl_reads", 64'(m_n), 64'd2);
    walk(20'h00402, 22'h1, 1'b0, lat);
    check("latency_2lvl", 64'(lat), 64'd5);

    // Aligned superpage.
    mem.delete(); err_map.delete();
    mem[34'h1000] = 32'h2000_000F;
    model_walk(20'h00123, 22'h1, m_pf, m_af, m_tag, m_phys, m_n);
    check("model_super_phys", 64'(m_phys), 64'h80123);
    walk(20'h00123, 22'h1, 1'b1, lat);
    check("latency_1lvl", 64'(lat), 64'd3);

    // Misaligned superpage.
    mem[34'h1000] = 32'h2000_040F;
    model_walk(20'h00123, 22'h1, m_pf, m_af, m_tag, m_phys, m_n);
    check("model_misaligned_pf", 64'(m_pf), 64'd1);
    check("model_misaligned_reads", 64'(m_n), 64'd1);
    walk(20'h00123, 22'h1, 1'b0, lat);

    // W without R, then V=0.
    mem[34'h1000] = 32'h0000_0005;
    walk(20'h00123, 22'h1, 1'b0, lat);
    mem[34'h1000] = 32'h0000_000E;
    walk(20'h00123, 22'h1, 1'b0, lat);

    // Stalled bus, error response.
    load_two_level();
    err_map[34'h1004] = 1'b1;
    cfg_stall = 4;
    model_walk(20'h00402, 22'h1, m_pf, m_af, m_tag, m_phys, m_n);
    check("model_busfault_af", 64'(m_af), 64'd1);
    walk(20'h00402, 22'h1, 1'b0, lat);
    cfg_stall = 0;

    // Reset while waiting on the level-0 read.
    load_two_level();
    cfg_delay = 6;
    reads = 0;
    exp_pending = 1'b0;
    @(negedge clk);
    resolve_request = 1'b1;
    resolve_virtual_address = 20'h00402;
    satp_ppn = 22'h1;
    for (int i = 0; i < 60 && reads < 2; i++) @(negedge clk);
    check("midwalk_reads_before_reset", 64'(reads), 64'd2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midwalk_reset");
    resolve_request = 1'b0;
    cfg_delay = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    walk(20'h00402, 22'h1, 1'b0, lat);

    // Randomised tables and bus timing.
    rand_bus = 1'b1;
    for (int t = 0; t < 60; t++) begin
      mem.delete(); err_map.delete();
      vpn = 20'($urandom);
      satp = 22'($urandom);
      a1 = {satp, vpn[19:10], 2'b00};
      case ($urandom_range(0, 2))
        0: begin
          ppn = 22'($urandom);
          mem[a1] = {ppn, 2'b00, 4'($urandom), 3'b000, 1'b1};
          a0 = {ppn, vpn[9:0], 2'b00};
          pte = $urandom;
          if ($urandom_range(0, 3) != 0) pte[0] = 1'b1;
          if ($urandom_range(0, 1) != 0) pte[3:1] = rwx_opts[$urandom_range(0, 4)];
          mem[a0] = pte;
          if ($urandom_range(0, 7) == 0) err_map[a0] = 1'b1;
        end
        1: mem[a1] = {12'($urandom), 10'd0, 2'b00, 4'($urandom),
                      rwx_opts[$urandom_range(0, 4)], 1'b1};
        default: mem[a1] = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) err_map[a1] = 1'b1;
      walk(vpn, satp, 1'($urandom_range(0, 1)), lat);
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
